// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler.
//   - Default widths and threshold used as parameter defaults.
//   - FSM state encoding (IDLE / UPDATE / DONE) as plain constants.
//   - sat_add: unsigned add clamped to an all-ones value of a given width.
package lif_pkg;

    localparam int LIF_DATA_W     = 8;
    localparam int LIF_IDX_W      = 2;
    localparam int LIF_THRESH_RST = 127;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_UPDATE = 2'd1;
    localparam fsm_state_t ST_DONE   = 2'd2;

    // Adds two values that fit in 'width' bits (width <= 31) and clamps
    // the result to 2^width - 1. The wide carry bit makes overflow visible.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky integrate-and-fire update for one neuron.
// Ports:
//   cur       in   input current for the selected neuron
//   state     in   current membrane state
//   threshold in   firing threshold
//   nxt       out  sat(cur + (state >> LEAK_SHIFT))
//   fire      out  nxt >= threshold
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int DATA_W     = LIF_DATA_W,
    parameter int LEAK_SHIFT = 1
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] state,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] nxt,
    output logic              fire
);

    logic [DATA_W-1:0] leaked;

    assign leaked = state >> LEAK_SHIFT;
    assign nxt    = DATA_W'(sat_add(32'(cur), 32'(leaked), DATA_W));
    assign fire   = (nxt >= threshold);

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed LIF scheduler: one update datapath walks N_NEURONS
// states in index order once per tick and emits spike events through a
// one-entry valid/ready register.
// Optional build macro: LIF_REFRACTORY_EN adds per-neuron refractory
// counters (REFRACT_TS passes of forced-zero state after a spike).
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   tick             timestep strobe, starts a pass when idle
//   current_in       packed per-neuron currents, neuron i at [i*DATA_W +: DATA_W]
//   cfg_we/cfg_threshold  threshold write, honoured only while idle
//   spike_valid/spike_idx/spike_ready  spike event handshake
//   busy             pass in progress
//   done             one-cycle pulse at end of pass
//   overrun          sticky: tick seen while busy
//   rd_idx/rd_state  combinational debug read of the state file
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int IDX_W      = LIF_IDX_W,
    parameter int DATA_W     = LIF_DATA_W,
    parameter int LEAK_SHIFT = 1,
    parameter int THRESH_RST = LIF_THRESH_RST,
    parameter int REFRACT_TS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [N_NEURONS*DATA_W-1:0] current_in,
    input  logic                        cfg_we,
    input  logic [DATA_W-1:0]           cfg_threshold,
    output logic                        spike_valid,
    output logic [IDX_W-1:0]            spike_idx,
    input  logic                        spike_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [DATA_W-1:0]           rd_state
);

    logic [DATA_W-1:0] state_mem [N_NEURONS];
    logic [DATA_W-1:0] shadow    [N_NEURONS];
    logic [DATA_W-1:0] threshold;
    fsm_state_t        fsm;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] nxt;
    logic              fire_raw;
    logic              fire;
    logic              refr_active;
    logic              stall;
    logic              commit;
    logic              last;

    lif_update_unit #(
        .DATA_W     (DATA_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .cur       (shadow[idx]),
        .state     (state_mem[idx]),
        .threshold (threshold),
        .nxt       (nxt),
        .fire      (fire_raw)
    );

`ifdef LIF_REFRACTORY_EN
    localparam int CNT_W = $clog2(REFRACT_TS + 1);

    logic [CNT_W-1:0] refr_cnt [N_NEURONS];

    assign refr_active = (refr_cnt[idx] != '0);

    // Counter only moves when the neuron actually commits, so a stalled
    // cycle never consumes refractory time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) refr_cnt[i] <= '0;
        end else if (commit) begin
            if (refr_active)
                refr_cnt[idx] <= refr_cnt[idx] - 1'b1;
            else if (fire)
                refr_cnt[idx] <= CNT_W'(REFRACT_TS);
        end
    end
`else
    logic unused_refract;

    assign refr_active    = 1'b0;
    assign unused_refract = ^REFRACT_TS;
`endif

    assign fire   = fire_raw & ~refr_active;
    // A new spike can only be loaded if the output slot is free or is
    // being drained in this same cycle.
    assign stall  = fire & spike_valid & ~spike_ready;
    assign commit = (fsm == ST_UPDATE) & ~stall;
    assign last   = (idx == IDX_W'(N_NEURONS - 1));

    assign busy     = (fsm != ST_IDLE);
    assign done     = (fsm == ST_DONE);
    assign rd_state = state_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm         <= ST_IDLE;
            idx         <= '0;
            threshold   <= DATA_W'(THRESH_RST);
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            overrun     <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) state_mem[i] <= '0;
        end else begin
            if (tick && (fsm != ST_IDLE))
                overrun <= 1'b1;

            if (commit && fire) begin
                spike_valid <= 1'b1;
                spike_idx   <= idx;
            end else if (spike_ready) begin
                spike_valid <= 1'b0;
            end

            case (fsm)
                ST_IDLE: begin
                    if (cfg_we)
                        threshold <= cfg_threshold;
                    if (tick) begin
                        idx <= '0;
                        fsm <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (commit) begin
                        state_mem[idx] <= (fire || refr_active) ? '0 : nxt;
                        if (last) begin
                            idx <= '0;
                            fsm <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: fsm <= ST_IDLE;
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // Currents are frozen at pass start so the source may change freely.
    always_ff @(posedge clk) begin
        if ((fsm == ST_IDLE) && tick) begin
            for (int i = 0; i < N_NEURONS; i++)
                shadow[i] <= current_in[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler (default parameters: 4 neurons,
// 8-bit data, leak >> 1, reset threshold 127, refractory feature off).
module tb_lif_neuron_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] current_in = '0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_threshold = '0;
    logic        spike_valid;
    logic [1:0]  spike_idx;
    logic        spike_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [1:0]  rd_idx = '0;
    logic [7:0]  rd_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] cur;
        logic [31:0] st;
        logic [3:0]  mask;
    } vec_t;

    vec_t tbl [8];

    lif_neuron_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .current_in    (current_in),
        .cfg_we        (cfg_we),
        .cfg_threshold (cfg_threshold),
        .spike_valid   (spike_valid),
        .spike_idx     (spike_idx),
        .spike_ready   (spike_ready),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .rd_idx        (rd_idx),
        .rd_state      (rd_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic check_states(input string nm, input logic [31:0] exp);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk($sformatf("%s_state%0d", nm, i), 32'(rd_state), 32'(exp[i*8 +: 8]));
        end
    endtask

    // Launch a pass; the source is scrambled afterwards to prove the
    // shadow copy is what gets used.
    task automatic start_tick(input logic [31:0] cur);
        current_in = cur;
        tick = 1'b1;
        step();
        tick = 1'b0;
        current_in = ~cur;
    endtask

    // Walk the pass until busy drops, logging events and the done pulse.
    // At sample 'inj' a stray tick and a threshold write of 0 are driven.
    task automatic collect(input int inj, output int busy_n, output int done_n,
                           output int done_at, output int ev_n,
                           output logic [3:0] mask, output int order_err);
        int last_ev;
        busy_n = 0; done_n = 0; done_at = -1; ev_n = 0; mask = '0;
        order_err = 0; last_ev = -1;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            tick   = (c == inj);
            cfg_we = (c == inj);
            if (c == inj) cfg_threshold = 8'd0;
            busy_n++;
            if (done) begin
                done_n++;
                done_at = c;
            end
            if (spike_valid && spike_ready) begin
                if (int'(spike_idx) <= last_ev) order_err++;
                last_ev = int'(spike_idx);
                mask[spike_idx] = 1'b1;
                ev_n++;
            end
            step();
        end
        tick = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic run_pass(input string nm, input logic [31:0] cur,
                            input logic [31:0] exp_st, input logic [3:0] exp_mask,
                            input int inj);
        int busy_n, done_n, done_at, ev_n, order_err;
        logic [3:0] mask;
        start_tick(cur);
        collect(inj, busy_n, done_n, done_at, ev_n, mask, order_err);
        chk({nm, "_busy_cycles"}, busy_n, 5);
        chk({nm, "_done_count"}, done_n, 1);
        chk({nm, "_done_cycle"}, done_at, 4);
        chk({nm, "_spike_mask"}, 32'(mask), 32'(exp_mask));
        chk({nm, "_spike_count"}, ev_n, $countones(exp_mask));
        chk({nm, "_spike_order"}, order_err, 0);
        chk({nm, "_valid_end"}, 32'(spike_valid), 0);
        check_states(nm, exp_st);
    endtask

    initial begin
        int busy_n, done_n, done_at, ev_n, order_err;
        logic [3:0] mask;

        // Chained vectors: each row starts from the previous row's states.
        tbl[0] = '{cur: {8'd40, 8'd30, 8'd20, 8'd10}, st: {8'd40, 8'd30, 8'd20, 8'd10}, mask: 4'b0000};
        tbl[1] = '{cur: {8'd0, 8'd100, 8'd0, 8'd0},   st: {8'd20, 8'd115, 8'd10, 8'd5}, mask: 4'b0000};
        tbl[2] = '{cur: {8'd0, 8'd100, 8'd0, 8'd0},   st: {8'd10, 8'd0, 8'd5, 8'd2},    mask: 4'b0100};
        tbl[3] = '{cur: {8'd0, 8'd100, 8'd0, 8'd0},   st: {8'd5, 8'd100, 8'd2, 8'd1},   mask: 4'b0000};
        tbl[4] = '{cur: {8'd0, 8'd0, 8'd0, 8'd0},     st: {8'd2, 8'd50, 8'd1, 8'd0},    mask: 4'b0000};
        tbl[5] = '{cur: {8'd0, 8'd0, 8'd0, 8'd127},   st: {8'd1, 8'd25, 8'd0, 8'd0},    mask: 4'b0001};
        tbl[6] = '{cur: {8'd0, 8'd0, 8'd1, 8'd126},   st: {8'd0, 8'd12, 8'd1, 8'd126},  mask: 4'b0000};
        tbl[7] = '{cur: {8'd0, 8'd0, 8'd130, 8'd200}, st: {8'd0, 8'd6, 8'd0, 8'd0},     mask: 4'b0011};

        // Reset state
        repeat (3) step();
        rst = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(spike_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_spike_idx", 32'(spike_idx), 0);
        check_states("rst", 32'd0);

        // Directed table, reset threshold 127, consumer always ready
        for (int r = 0; r < 8; r++)
            run_pass($sformatf("vec%0d", r), tbl[r].cur, tbl[r].st, tbl[r].mask, -1);
        chk("table_overrun", 32'(overrun), 0);

        // Back-pressure: event 0 held, FSM stalls at neuron 1
        spike_ready = 1'b0;
        start_tick({8'd200, 8'd200, 8'd200, 8'd200});
        repeat (6) step();
        chk("stall_valid", 32'(spike_valid), 1);
        chk("stall_idx", 32'(spike_idx), 0);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_done", 32'(done), 0);
        rd_idx = 2'd2;
        #1;
        chk("stall_state2_held", 32'(rd_state), 6);
        spike_ready = 1'b1;
        collect(-1, busy_n, done_n, done_at, ev_n, mask, order_err);
        chk("stall_busy_cycles", busy_n, 4);
        chk("stall_done_count", done_n, 1);
        chk("stall_done_cycle", done_at, 3);
        chk("stall_spike_mask", 32'(mask), 32'hF);
        chk("stall_spike_count", ev_n, 4);
        chk("stall_spike_order", order_err, 0);
        check_states("stall", 32'd0);

        // Threshold write in idle, then saturation at 255
        do_reset();
        cfg_threshold = 8'd255;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        run_pass("cfg_a", {8'd200, 8'd200, 8'd200, 8'd200}, {8'd200, 8'd200, 8'd200, 8'd200}, 4'b0000, -1);
        run_pass("cfg_b", {8'd200, 8'd200, 8'd200, 8'd200}, 32'd0, 4'b1111, -1);

        // Stray tick and threshold write while busy
        run_pass("ovr", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000, 1);
        chk("ovr_set", 32'(overrun), 1);
        run_pass("ovr_next", 32'd0, {8'd2, 8'd1, 8'd1, 8'd0}, 4'b0000, -1);
        chk("ovr_sticky", 32'(overrun), 1);

        // Reset in the middle of a stalled pass
        spike_ready = 1'b0;
        start_tick({8'd255, 8'd255, 8'd255, 8'd255});
        step();
        chk("midrst_pre_valid", 32'(spike_valid), 1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_valid", 32'(spike_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        chk("midrst_done", 32'(done), 0);
        check_states("midrst", 32'd0);
        step();
        chk("midrst_idle_hold", 32'(busy), 0);

        // Threshold restored to 127 by reset
        spike_ready = 1'b1;
        run_pass("thr_rst", {8'd127, 8'd0, 8'd0, 8'd0}, 32'd0, 4'b1000, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_neuron_scheduler.md
Name: lif_neuron_scheduler

Overview:
Time-multiplexes one leaky integrate-and-fire update datapath across N_NEURONS neuron states held in a local register file. Each global timestep `tick` starts one pass: every neuron is updated in index order. Spikes are emitted as indexed events over a one-entry valid/ready output. Sits between the stimulus/current source and the spike-routing fabric, and owns the threshold configuration.

Parameters:
N_NEURONS, 4, number of neurons sharing the datapath (2..256)
IDX_W, 2, neuron index width; must equal clog2(N_NEURONS)
DATA_W, 8, membrane state and input current width
LEAK_SHIFT, 1, leak applied as state >> LEAK_SHIFT per timestep
THRESH_RST, 127, threshold value after reset
REFRACT_TS, 2, refractory length in timesteps (used only with LIF_REFRACTORY_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
tick  in  1  timestep strobe; starts a pass when idle
current_in  in  N_NEURONS*DATA_W  per-neuron input current; neuron i at bits [i*DATA_W +: DATA_W]
cfg_we  in  1  threshold write strobe
cfg_threshold  in  DATA_W  new threshold value
spike_valid  out  1  spike event pending
spike_idx  out  IDX_W  index of the spiking neuron
spike_ready  in  1  consumer accepts the event
busy  out  1  pass in progress (state != IDLE)
done  out  1  one-cycle pulse at end of pass
overrun  out  1  sticky: tick arrived while busy
rd_idx  in  IDX_W  debug read index
rd_state  out  DATA_W  combinational read of state[rd_idx]

Behaviour:
- Reset (rst=0 at a clk edge): all states = 0, threshold = THRESH_RST, FSM = IDLE, idx = 0, spike_valid = 0, spike_idx = 0, done = 0, overrun = 0, refractory counters = 0. Reset mid-pass aborts the pass; no event survives.
- FSM states: IDLE, UPDATE, DONE.
- IDLE: on tick=1, latch current_in into a shadow register, set idx = 0, go to UPDATE. cfg_we=1 in IDLE loads threshold at that edge. cfg_we outside IDLE is ignored.
- UPDATE: compute nxt = sat(cur[idx] + (state[idx] >> LEAK_SHIFT)); the sum is DATA_W+1 bits, saturating to 2^DATA_W-1. fire = (nxt >= threshold).
- Stall: if fire=1 and spike_valid=1 and spike_ready=0, nothing commits; idx holds.
- Commit (no stall): state[idx] = fire ? 0 : nxt. If fire, spike_valid=1 and spike_idx=idx at the same edge. Then idx++; if idx was N_NEURONS-1, go to DONE.
- Output handshake: spike_valid clears on spike_valid & spike_ready unless a new fire is loaded in the same cycle (a back-to-back event is allowed). spike_valid/spike_idx stay stable while unaccepted.
- DONE: done=1 for exactly this cycle, then IDLE. A tick in DONE is an overrun.
- Latency with no stalls: tick sampled at edge t0; neuron i commits at edge t0+1+i; done is high during cycle t0+N_NEURONS+1; a new tick is accepted from t0+N_NEURONS+2.
- A tick while busy (UPDATE or DONE) sets overrun (sticky until rst) and is otherwise ignored.
- current_in changes during a pass have no effect; the shadow copy is used.

Optional Feature:
LIF_REFRACTORY_EN. Defined: each neuron has a counter, loaded with REFRACT_TS on fire. While the counter is nonzero, the neuron's commit forces state = 0, fire = 0, and the counter decrements once per pass. Undefined: no counters; a neuron integrates normally in the timestep after a spike.

Decomposition:
- Package lif_pkg: DATA_W/IDX_W defaults, THRESH_RST, FSM state enum, sat_add function.
- Sub-module lif_update_unit (combinational): leak shift, saturating add, threshold compare. Outputs nxt and fire.
- Register file, FSM, and handshake stay in lif_neuron_scheduler.

Test Plan:
1. Release rst after 3 cycles -> all rd_state=0, busy=0, spike_valid=0, overrun=0; threshold 127 confirmed by scenario 3.
2. tick with currents {10,20,30,40}, spike_ready=1 -> states 10,20,30,40; busy for 5 cycles; done pulses once at t0+5; no spike.
3. Three ticks with current 100 on neuron 2 only -> state 100, then 150 fires (spike_idx=2, state 0), then 100.
4. Currents 200 on all neurons, spike_ready=0 -> event idx0 held and FSM stalls at idx1; then spike_ready=1 -> events 0,1,2,3 in order, each handshaken once, done after the last commit.
5. cfg_we in IDLE with cfg_threshold=255, tick 200 then tick 200 -> state 200, then 100+200 saturates to 255, fires, state 0.
6. Second tick during UPDATE -> overrun=1, single pass only. cfg_we during UPDATE -> threshold unchanged. rst=0 mid-pass -> all state 0, spike_valid=0, IDLE.
